// File: rtl/garo_pkg.sv
// garo_pkg: shared constants and helpers for the GaRO entropy source.
//   LFSR_SEED / LFSR_FB_MASK : deterministic test source seed and feedback taps
//   mode_e                   : encoding of the 2-bit mode input
//   coll_state_e             : word collector states
//   lfsr_next()              : one step of the 16-bit Fibonacci test LFSR
//   ring_params_ok()         : legality check for a ring length / polynomial pair
package garo_pkg;

  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 on a right-shifting register: taps on bits 0,2,3,5
  localparam logic [15:0] LFSR_FB_MASK = 16'h002D;

  typedef enum logic [1:0] {
    MODE_RING  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_STUCK = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_FULL,
    ST_FAIL
  } coll_state_e;

  // Bit 0 is the output bit; the feedback enters at bit 15.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_FB_MASK), s[15:1]};
  endfunction

  // Length must be 3..32 and the top tap must be set, otherwise the ring
  // degenerates into a shorter polynomial than the one asked for.
  function automatic bit ring_params_ok(input int unsigned len, input logic [31:0] poly);
    if (len < 3 || len > 32) return 1'b0;
    return poly[5'(len - 1)];
  endfunction

endpackage

// File: rtl/garo_ring.sv
// garo_ring: one free-running Galois ring oscillator.
//   en       : ring enable; low parks every stage at 0
//   ring_out : raw (asynchronous) stage nets, RING_LEN bits
// Stage 0 inverts the last stage; every other stage inverts the previous one,
// XORed with the last stage where POLY has a tap. Each stage is one SB_LUT4
// (I0 = previous stage, I1 = feedback, I2 = enable). Outside synthesis the
// loop cannot be simulated, so the outputs read as X while running.
module garo_ring
  import garo_pkg::*;
#(
  parameter int unsigned         RING_LEN = 11,
  parameter logic [RING_LEN-1:0] POLY     = 11'b10111110010
) (
  input  logic                en,
  output logic [RING_LEN-1:0] ring_out
);

  localparam bit PARAMS_OK = ring_params_ok(RING_LEN, 32'(POLY));

  // Illegal parameters keep the ring parked rather than oscillating wrongly.
  (* keep *) logic ring_en;
  assign ring_en = en & PARAMS_OK;

`ifdef SYNTHESIS
  (* keep *) logic [RING_LEN-1:0] stage;

  for (genvar i = 0; i < RING_LEN; i++) begin : g_stage
    if (i == 0) begin : g_head
      // O = I2 & ~I0
      (* keep *) SB_LUT4 #(.LUT_INIT(16'h0050)) u_lut (
        .O (stage[0]),
        .I0(stage[RING_LEN-1]),
        .I1(1'b0),
        .I2(ring_en),
        .I3(1'b0)
      );
    end else begin : g_body
      // tapped: O = I2 & ~(I0 ^ I1); untapped: O = I2 & ~I0
      (* keep *) SB_LUT4 #(.LUT_INIT(POLY[i] ? 16'h0090 : 16'h0050)) u_lut (
        .O (stage[i]),
        .I0(stage[i-1]),
        .I1(stage[RING_LEN-1]),
        .I2(ring_en),
        .I3(1'b0)
      );
    end
  end

  assign ring_out = stage;
`else
  assign ring_out = ring_en ? 'x : '0;
`endif

endmodule

// File: rtl/garo_entropy_src.sv
// garo_entropy_src: multi-ring GaRO entropy source with word collector and
// repetition-count health test.
//   clk, reset_n : clock, synchronous active-low reset
//   en           : run enable; low stops the rings and clears collector/health state
//   mode         : 0/3 rings, 1 LFSR test source, 2 stuck-at-1 test source
//   word_ready   : consumer accepts word_data this cycle
//   word_valid   : word_data holds a complete word
//   word_data    : collected word, newest bit in bit 0
//   health_fail  : sticky repetition-count failure
module garo_entropy_src
  import garo_pkg::*;
#(
  parameter int unsigned         NUM_RINGS  = 4,
  parameter int unsigned         RING_LEN   = 11,
  parameter logic [RING_LEN-1:0] POLY       = 11'b10111110010,
  parameter int unsigned         SAMPLE_DIV = 16,
  parameter int unsigned         WORD_W     = 32,
  parameter int unsigned         RCT_CUTOFF = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              word_ready,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              health_fail
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned CNT_W = $clog2(WORD_W + 1);
  localparam int unsigned RUN_W = $clog2(RCT_CUTOFF + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(RCT_CUTOFF);

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  // ---------------------------------------------------------------- rings
  logic                ring_en;
  logic [RING_LEN-1:0] ring_net [NUM_RINGS];
  logic [RING_LEN-1:0] ring_q   [NUM_RINGS];
  logic                ring_mix;
  logic                ring_xor_q;

  assign ring_en = en && reset_n && (mode_sel == MODE_RING || mode_sel == MODE_RSVD);

  for (genvar r = 0; r < NUM_RINGS; r++) begin : g_ring
    garo_ring #(
      .RING_LEN(RING_LEN),
      .POLY    (POLY)
    ) u_ring (
      .en      (ring_en),
      .ring_out(ring_net[r])
    );
  end

  always_comb begin
    ring_mix = 1'b0;
    for (int unsigned r = 0; r < NUM_RINGS; r++) begin
      ring_mix = ring_mix ^ (^ring_q[r]);
    end
  end

  // Two flops on every ring path: stage capture, then the combined XOR.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_RINGS; r++) ring_q[r] <= '0;
      ring_xor_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_RINGS; r++) ring_q[r] <= ring_net[r];
      ring_xor_q <= ring_mix;
    end
  end

  // ------------------------------------------------- sampling and health
  logic [DIV_W-1:0] div_q;
  logic             strobe;
  logic             src_bit;
  logic [15:0]      lfsr_q;
  logic             s1_valid, s1_bit;
  logic             s2_valid, s2_bit;
  coll_state_e      state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [RUN_W-1:0] run_len_q, run_next;
  logic             prev_raw_q;
  logic             rct_trip;

  assign strobe = en && (div_q == DIV_LAST);

  always_comb begin
    src_bit = ring_xor_q;
    case (mode_sel)
      MODE_LFSR:  src_bit = lfsr_q[0];
      MODE_STUCK: src_bit = 1'b1;
      default:    src_bit = ring_xor_q;
    endcase
  end

  // run_len_q == 0 means no previous bit yet, so the first bit starts a run of 1.
  // The count saturates at the limit; the flag is sticky anyway.
  always_comb begin
    run_next = RUN_W'(1);
    if (run_len_q != '0 && s2_bit == prev_raw_q) begin
      run_next = (run_len_q == RUN_LIMIT) ? run_len_q : run_len_q + RUN_W'(1);
    end
    rct_trip = s2_valid && (run_next == RUN_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      s1_valid    <= 1'b0;
      s1_bit      <= 1'b0;
      s2_valid    <= 1'b0;
      s2_bit      <= 1'b0;
      state_q     <= ST_COLLECT;
      bit_cnt_q   <= '0;
      run_len_q   <= '0;
      prev_raw_q  <= 1'b0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      health_fail <= 1'b0;
    end else if (!en) begin
      // LFSR deliberately keeps its state; only reset reseeds it.
      div_q       <= '0;
      s1_valid    <= 1'b0;
      s1_bit      <= 1'b0;
      s2_valid    <= 1'b0;
      s2_bit      <= 1'b0;
      state_q     <= ST_COLLECT;
      bit_cnt_q   <= '0;
      run_len_q   <= '0;
      prev_raw_q  <= 1'b0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      health_fail <= 1'b0;
    end else begin
      div_q    <= strobe ? '0 : div_q + DIV_W'(1);
      s1_valid <= strobe;
      if (strobe) begin
        s1_bit <= src_bit;
        if (mode_sel == MODE_LFSR) lfsr_q <= lfsr_next(lfsr_q);
      end
      s2_valid <= s1_valid;
      s2_bit   <= s1_bit;

      // The health test sees every raw bit, including those the collector drops.
      if (s2_valid) begin
        run_len_q  <= run_next;
        prev_raw_q <= s2_bit;
      end

      case (state_q)
        ST_COLLECT: begin
          if (rct_trip) begin
            state_q     <= ST_FAIL;
            word_valid  <= 1'b0;
            health_fail <= 1'b1;
          end else if (s2_valid) begin
            word_data <= {word_data[WORD_W-2:0], s2_bit};
            if (bit_cnt_q == CNT_LAST) begin
              bit_cnt_q  <= CNT_W'(WORD_W);
              word_valid <= 1'b1;
              state_q    <= ST_FULL;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FULL: begin
          if (rct_trip) begin
            state_q     <= ST_FAIL;
            word_valid  <= 1'b0;
            health_fail <= 1'b1;
          end else if (word_ready) begin
            // A bit arriving in the transfer cycle opens the next word.
            word_valid <= 1'b0;
            state_q    <= ST_COLLECT;
            word_data  <= s2_valid ? WORD_W'(s2_bit) : '0;
            bit_cnt_q  <= s2_valid ? CNT_W'(1) : '0;
          end
        end
        ST_FAIL: begin
          word_valid  <= 1'b0;
          health_fail <= 1'b1;
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_garo_entropy_src.sv
// tb_garo_entropy_src: directed bench for garo_entropy_src using the LFSR and
// stuck-at-1 test sources (SAMPLE_DIV=4, WORD_W=8, RCT_CUTOFF=32).
// "cyc" counts cycles from the cycle in which en was raised (cycle 0);
// strobe k (1-based) lands in cycle 4k-1 and its bit reaches the collector in
// cycle 4k+1, so a word completed by strobe k is visible in cycle 4k+2.
module tb_garo_entropy_src;

  localparam int unsigned WW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [1:0]    mode;
  logic          word_ready;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic          health_fail;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;
  logic        lbit [1:64];

  always #5 clk = ~clk;

  garo_entropy_src #(
    .NUM_RINGS (4),
    .RING_LEN  (11),
    .POLY      (11'b10111110010),
    .SAMPLE_DIV(4),
    .WORD_W    (WW),
    .RCT_CUTOFF(32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .mode       (mode),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .health_fail(health_fail)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Expected word built from LFSR outputs of strobes first..first+WW-1, oldest in the MSB.
  function automatic logic [WW-1:0] word_from(input int first);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < int'(WW); k++) w = {w[WW-2:0], lbit[first + k]};
    return w;
  endfunction

  initial begin
    logic [15:0] s;
    s = 16'hACE1;
    for (int k = 1; k <= 64; k++) begin
      lbit[k] = s[0];
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end

    reset_n    = 1'b0;
    en         = 1'b0;
    mode       = 2'd1;
    word_ready = 1'b0;

    // 1: reset held with en=1, mode=1
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid", 64'(word_valid), 64'd0);
      check("rst_data", 64'(word_data), 64'd0);
      check("rst_fail", 64'(health_fail), 64'd0);
    end
    reset_n = 1'b1;
    step();
    check("rel_valid", 64'(word_valid), 64'd0);
    check("rel_data", 64'(word_data), 64'd0);
    check("rel_fail", 64'(health_fail), 64'd0);
    en      = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // 2: first LFSR word
    word_ready = 1'b1;
    en         = 1'b1;
    cyc        = 0;
    run_to(33);
    check("w1_valid_early", 64'(word_valid), 64'd0);
    run_to(34);
    check("w1_valid", 64'(word_valid), 64'd1);
    check("w1_data_hand", 64'(word_data), 64'h87);
    check("w1_data_model", 64'(word_data), 64'(word_from(1)));
    word_ready = 1'b0;

    // 3: 50 cycles of backpressure, then one transfer
    while (cyc < 83) begin
      step();
      check("bp_valid", 64'(word_valid), 64'd1);
      check("bp_data", 64'(word_data), 64'h87);
    end
    run_to(84);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("xfer_valid_clr", 64'(word_valid), 64'd0);
    run_to(113);
    check("w2_valid_early", 64'(word_valid), 64'd0);
    run_to(114);
    check("w2_valid", 64'(word_valid), 64'd1);
    check("w2_data", 64'(word_data), 64'(word_from(21)));

    // 6: transfer in the cycle strobe 29's bit arrives
    run_to(117);
    check("w2_hold", 64'(word_valid), 64'd1);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("sim_valid_clr", 64'(word_valid), 64'd0);
    check("sim_first_bit", 64'(word_data), 64'(lbit[29]));
    run_to(145);
    check("w3_valid_early", 64'(word_valid), 64'd0);
    run_to(146);
    check("w3_valid", 64'(word_valid), 64'd1);
    check("w3_data", 64'(word_data), 64'(word_from(29)));

    // 4: stuck-at-1 source from a fresh reset trips the RCT after 32 strobes
    en      = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    mode    = 2'd2;
    en      = 1'b1;
    cyc     = 0;
    run_to(34);
    check("stuck_valid", 64'(word_valid), 64'd1);
    check("stuck_data", 64'(word_data), 64'hFF);
    run_to(127);
    check("rct_pre_strobe32", 64'(health_fail), 64'd0);
    run_to(129);
    check("rct_pre_trip", 64'(health_fail), 64'd0);
    check("rct_pre_valid", 64'(word_valid), 64'd1);
    run_to(130);
    check("rct_trip", 64'(health_fail), 64'd1);
    check("rct_valid_off", 64'(word_valid), 64'd0);
    run_to(140);
    check("rct_sticky", 64'(health_fail), 64'd1);
    check("rct_valid_held_off", 64'(word_valid), 64'd0);

    // 5: en low for one cycle clears the flag; the LFSR was not stepped in mode 2
    en = 1'b0;
    step();
    check("enclr_fail", 64'(health_fail), 64'd0);
    check("enclr_valid", 64'(word_valid), 64'd0);
    check("enclr_data", 64'(word_data), 64'd0);
    mode       = 2'd1;
    word_ready = 1'b1;
    en         = 1'b1;
    cyc        = 0;
    run_to(33);
    check("w4_valid_early", 64'(word_valid), 64'd0);
    run_to(34);
    check("w4_valid", 64'(word_valid), 64'd1);
    check("w4_data", 64'(word_data), 64'h87);
    check("w4_fail", 64'(health_fail), 64'd0);

    // 5b: trip again, then clear with reset
    word_ready = 1'b0;
    en         = 1'b0;
    step();
    mode = 2'd2;
    en   = 1'b1;
    cyc  = 0;
    run_to(130);
    check("rct2_trip", 64'(health_fail), 64'd1);
    reset_n = 1'b0;
    step();
    check("rstclr_fail", 64'(health_fail), 64'd0);
    check("rstclr_valid", 64'(word_valid), 64'd0);
    check("rstclr_data", 64'(word_data), 64'd0);
    reset_n = 1'b1;
    en      = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
